matmul_dsp_sched: RTL and testbench
===================================

# matmul_dsp_sched

Parametrised successor to the fixed 4x16x16x4 matrix multiplier. Computes C = A x B for M x K and K x N operands by time-multiplexing NUM_DSP external DSP multiplier lanes. Sits between the NPU operand buffers and the hard DSP slices. Unlike the previous generation it:
- accepts any DSP pipeline latency;
- clears its accumulators on start;
- supports signed and unsigned operands;
- holds results stable until the next start.

## Interface
Parameters:
- M, 4, rows of A and C
- K, 16, inner dimension
- N, 4, columns of B and C
- DATA_W, 8, operand width (at most 18)
- ACC_W, 24, accumulator and result width (at most 37)
- NUM_DSP, 5, external multiplier lanes
- DSP_LAT, 1, cycles from a dsp_a/dsp_b register update to the matching dsp_out (at least 1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a computation; ignored while busy
- signed_mode  in  1  1 = two's-complement operands; sampled at start
- a  in  [M][K] x DATA_W  operand A; sampled at start
- b  in  [K][N] x DATA_W  operand B; sampled at start
- c  out  [M][N] x ACC_W  results; reset value 0
- dsp_a, dsp_b  out  [NUM_DSP] x 18  multiplier operands (registered); reset value 0
- dsp_out  in  [NUM_DSP] x 37  multiplier products
- dsp_ce  out  1  DSP clock enable; reset value 0
- busy  out  1  high from the cycle after an accepted start until done; reset value 0
- done  out  1  one-cycle completion pulse; reset value 0

## Operation
States and transitions:
- IDLE: waits for start.
- On start, go to LOAD: snapshot a, b and signed_mode; clear every c to 0; set busy.
- ISSUE: runs P = ceil(M·N/NUM_DSP) passes of K cycles each.
  - In pass p, lane l owns output index o = p·NUM_DSP + l, in row-major order: i = o / N, j = o % N.
  - At step k the lane drives a[i][k] and b[k][j], widened to 18 bits. Zero-extend when unsigned; sign-extend when signed.
  - If o ≥ M·N the lane is inactive: it drives 0 operands and its result is never accumulated.
- DRAIN: DSP_LAT cycles, flushing in-flight products.
- DONE: pulse done for one cycle, drop busy, return to IDLE.

Tag pipeline:
- Every issue carries a tag {valid, output index per lane} through a DSP_LAT-deep shift register.
- When the tag emerges, each valid lane does c[o] <= c[o] + dsp_out[l][ACC_W-1:0].
- Accumulation wraps modulo 2^ACC_W.
- In signed mode the lower ACC_W bits of the two's-complement product are used.

dsp_ce:
- High from the first ISSUE cycle through the last DRAIN cycle.
- Low in IDLE, LOAD and DONE.

c:
- Readable at any time; only stable when busy = 0.
- Holds its values after done until the next accepted start.

## Timing
- Start sampled high in IDLE at edge 0.
  - LOAD at edge 1.
  - First dsp_a/dsp_b update at edge 2.
  - Last issue at edge 1 + P·K.
  - Last accumulate at edge 1 + P·K + DSP_LAT.
  - done high for the cycle after that edge.
- Total start-to-done latency is P·K + DSP_LAT + 2 cycles. Defaults give 4·16 + 1 + 2 = 67.
- start while busy (including the done cycle) is ignored.
  - start held high through done re-triggers in the following IDLE cycle.
- Reset mid-operation: all state, tags, c and the DSP outputs clear immediately. No done is produced.
- Elaboration rejects NUM_DSP > M·N, DATA_W > 18, ACC_W > 37 and DSP_LAT < 1.

## Structure
- Package matmul_pkg holds:
  - DSP_OPND_W = 18 and DSP_PROD_W = 37;
  - the state enum (IDLE, LOAD, ISSUE, DRAIN, DONE);
  - a function ext18(value, signed_mode).
- Sub-module mm_tag_pipe, parametrised by DSP_LAT and NUM_DSP, carries per-lane valid bits and output indices aligned with the DSP latency.
- The testbench provides a behavioural DSP model of configurable latency.

## Test plan
- Defaults, A = identity-like (a[i][i] = 1 for i < 4, else 0), B random unsigned -> c[i][j] = b[i][j]; done at cycle 67.
- Defaults unsigned, all operands 255 -> every c = 1,040,400. Lanes 1–4 in pass 3 drive 0 and do not alter c.
- Signed, a = -128 and b = -128 everywhere -> c = 262,144. Then a = -1, b = 1 -> c = 0xFFFFF0 (-16).
- DSP_LAT = 3, NUM_DSP = 16, M = N = 4, K = 8 -> one pass; done 8 + 3 + 2 = 13 cycles after start; results match a golden model.
- start pulsed mid-run and during done -> ignored. A second start after IDLE clears c and recomputes correctly.
- rst_n asserted at ISSUE pass 2 -> c, dsp_a, dsp_ce, busy are 0 immediately; no done; a fresh run afterwards is correct.

Source files
------------

// File: rtl/matmul_dsp_sched_pkg.sv
// matmul_pkg: shared types and helpers for the DSP-scheduled matrix multiplier.
//   DSP_OPND_W / DSP_PROD_W : operand and product widths of the hard DSP slice
//   mm_state_e               : scheduler FSM states
//   ext18()                  : widen a DATA_W-bit operand to the DSP operand width
package matmul_pkg;

  localparam int DSP_OPND_W = 18;
  localparam int DSP_PROD_W = 37;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } mm_state_e;

  // value holds the operand zero-extended in its low `width` bits; the upper
  // bits are replaced by copies of bit width-1 when signed_mode is set.
  function automatic logic [DSP_OPND_W-1:0] ext18(
    input logic [DSP_OPND_W-1:0] value,
    input logic                  signed_mode,
    input int unsigned           width
  );
    logic [DSP_OPND_W-1:0] mask;
    logic                  sb;
    mask = '1 << width;
    sb   = |((value >> (width - 1)) & DSP_OPND_W'(1));
    return (signed_mode && sb) ? (value | mask) : (value & ~mask);
  endfunction

endpackage

// File: rtl/matmul_dsp_sched_tag_pipe.sv
// mm_tag_pipe: per-lane {valid, output index} delay line matched to the DSP
// pipeline latency, so each product meets its destination index on arrival.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_valid    : per-lane issue valid (registered together with the operands)
//   i_idx      : per-lane output index for that issue
//   o_valid    : per-lane valid aligned with dsp_out
//   o_idx      : per-lane output index aligned with dsp_out
module mm_tag_pipe #(
  parameter int DSP_LAT = 1,
  parameter int NUM_DSP = 5,
  parameter int IDX_W   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_DSP-1:0]              i_valid,
  input  logic [NUM_DSP-1:0][IDX_W-1:0]   i_idx,
  output logic [NUM_DSP-1:0]              o_valid,
  output logic [NUM_DSP-1:0][IDX_W-1:0]   o_idx
);

  logic [DSP_LAT-1:0][NUM_DSP-1:0]            r_v;
  logic [DSP_LAT-1:0][NUM_DSP-1:0][IDX_W-1:0] r_idx;

  if (DSP_LAT == 1) begin : g_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= '0;
        r_idx <= '0;
      end else begin
        r_v   <= i_valid;
        r_idx <= i_idx;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= '0;
        r_idx <= '0;
      end else begin
        r_v   <= {r_v[DSP_LAT-2:0], i_valid};
        r_idx <= {r_idx[DSP_LAT-2:0], i_idx};
      end
    end
  end

  assign o_valid = r_v[DSP_LAT-1];
  assign o_idx   = r_idx[DSP_LAT-1];

endmodule

// File: rtl/matmul_dsp_sched.sv
// matmul_dsp_sched: C = A x B (M x K times K x N) scheduled over NUM_DSP
// external DSP multiplier lanes with DSP_LAT cycles of product latency.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a computation (ignored unless idle)
//   signed_mode  : two's-complement operands when 1 (sampled at start)
//   a, b         : operands (sampled at start)
//   c            : results, row-major; stable while busy = 0
//   dsp_a, dsp_b : registered multiplier operands per lane
//   dsp_out      : multiplier products per lane
//   dsp_ce       : DSP clock enable, high through ISSUE and DRAIN
//   busy, done   : run in progress / one-cycle completion pulse
module matmul_dsp_sched
  import matmul_pkg::*;
#(
  parameter int M       = 4,
  parameter int K       = 16,
  parameter int N       = 4,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 24,
  parameter int NUM_DSP = 5,
  parameter int DSP_LAT = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic                                  signed_mode,
  input  logic [M-1:0][K-1:0][DATA_W-1:0]       a,
  input  logic [K-1:0][N-1:0][DATA_W-1:0]       b,
  output logic [M-1:0][N-1:0][ACC_W-1:0]        c,
  output logic [NUM_DSP-1:0][DSP_OPND_W-1:0]    dsp_a,
  output logic [NUM_DSP-1:0][DSP_OPND_W-1:0]    dsp_b,
  input  logic [NUM_DSP-1:0][DSP_PROD_W-1:0]    dsp_out,
  output logic                                  dsp_ce,
  output logic                                  busy,
  output logic                                  done
);

  localparam int MN    = M * N;
  localparam int P     = (MN + NUM_DSP - 1) / NUM_DSP;
  localparam int IDX_W = (MN > 1) ? $clog2(MN) : 1;
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int IW    = (M > 1) ? $clog2(M) : 1;
  localparam int JW    = (N > 1) ? $clog2(N) : 1;
  localparam int LW    = (NUM_DSP > 1) ? $clog2(NUM_DSP) : 1;
  localparam int DW    = $clog2(DSP_LAT + 1);

  if (NUM_DSP > MN)      begin : g_chk_dsp $error("NUM_DSP exceeds M*N");   end
  if (DATA_W > 18)       begin : g_chk_dw  $error("DATA_W exceeds 18");     end
  if (ACC_W > 37)        begin : g_chk_aw  $error("ACC_W exceeds 37");      end
  if (DSP_LAT < 1)       begin : g_chk_lat $error("DSP_LAT must be >= 1");  end

  mm_state_e                              r_state, w_next;
  logic [M-1:0][K-1:0][DATA_W-1:0]        r_a;
  logic [K-1:0][N-1:0][DATA_W-1:0]        r_b;
  logic                                   r_sm;
  logic [PW-1:0]                          r_pass;
  logic [KW-1:0]                          r_k;
  logic [DW-1:0]                          r_drain;
  logic [MN-1:0][ACC_W-1:0]               r_c;
  logic [NUM_DSP-1:0][DSP_OPND_W-1:0]     r_dsp_a, r_dsp_b;

  logic [NUM_DSP-1:0][DSP_OPND_W-1:0]     w_opa, w_opb;
  logic [NUM_DSP-1:0]                     w_iss_v, w_tag_v;
  logic [NUM_DSP-1:0][IDX_W-1:0]          w_iss_idx, w_tag_idx;
  logic                                   w_last_issue;
  logic                                   w_unused_prod;

  assign w_last_issue = (r_state == S_ISSUE) && (r_pass == PW'(P - 1)) && (r_k == KW'(K - 1));
  assign w_unused_prod = ^dsp_out;

  // Lane l in pass p owns output o = p*NUM_DSP + l; lanes past M*N idle at 0.
  for (genvar l = 0; l < NUM_DSP; l++) begin : g_lane
    logic [31:0]   w_o_full, w_o;
    logic          w_act;
    logic [IW-1:0] w_i;
    logic [JW-1:0] w_j;
    assign w_o_full     = 32'(r_pass) * 32'(NUM_DSP) + 32'(l);
    assign w_act        = (r_state == S_ISSUE) && (w_o_full < 32'(MN));
    assign w_o          = w_act ? w_o_full : '0;
    assign w_i          = IW'(w_o / 32'(N));
    assign w_j          = JW'(w_o % 32'(N));
    assign w_opa[l]     = w_act ? ext18(DSP_OPND_W'(r_a[w_i][r_k]), r_sm, DATA_W) : '0;
    assign w_opb[l]     = w_act ? ext18(DSP_OPND_W'(r_b[r_k][w_j]), r_sm, DATA_W) : '0;
    assign w_iss_v[l]   = w_act;
    assign w_iss_idx[l] = IDX_W'(w_o);
  end

  mm_tag_pipe #(
    .DSP_LAT (DSP_LAT),
    .NUM_DSP (NUM_DSP),
    .IDX_W   (IDX_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_iss_v),
    .i_idx   (w_iss_idx),
    .o_valid (w_tag_v),
    .o_idx   (w_tag_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    dsp_ce = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  begin busy = 1'b1; w_next = S_ISSUE; end
      S_ISSUE: begin
        busy   = 1'b1;
        dsp_ce = 1'b1;
        if (w_last_issue) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        dsp_ce = 1'b1;
        if (r_drain == DW'(DSP_LAT - 1)) w_next = S_DONE;
      end
      S_DONE:  begin done = 1'b1; w_next = S_IDLE; end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sm    <= 1'b0;
      r_pass  <= '0;
      r_k     <= '0;
      r_drain <= '0;
      r_c     <= '0;
      r_dsp_a <= '0;
      r_dsp_b <= '0;
    end else begin
      r_dsp_a <= w_opa;
      r_dsp_b <= w_opb;
      if (r_state == S_IDLE && start) begin
        r_a  <= a;
        r_b  <= b;
        r_sm <= signed_mode;
        r_c  <= '0;
      end else begin
        for (int unsigned l = 0; l < NUM_DSP; l++) begin
          if (w_tag_v[LW'(l)])
            r_c[w_tag_idx[LW'(l)]] <= r_c[w_tag_idx[LW'(l)]] + dsp_out[LW'(l)][ACC_W-1:0];
        end
      end
      if (r_state == S_LOAD) begin
        r_pass <= '0;
        r_k    <= '0;
      end else if (r_state == S_ISSUE) begin
        if (r_k == KW'(K - 1)) begin
          r_k    <= '0;
          r_pass <= r_pass + 1'b1;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
      if (r_state == S_DRAIN) r_drain <= r_drain + 1'b1;
      else                    r_drain <= '0;
    end
  end

  assign c     = r_c;
  assign dsp_a = r_dsp_a;
  assign dsp_b = r_dsp_b;

endmodule

// File: tb/tb_matmul_dsp_sched.sv
// Bench for matmul_dsp_sched: a default instance (4x16x4, 5 lanes, latency 1)
// and a one-pass instance (4x8x4, 16 lanes, latency 3), each driving a
// behavioural DSP model.
module tb_matmul_dsp_sched;
  import matmul_pkg::*;

  localparam int M = 4, K = 16, N = 4, DW = 8, AW = 24, ND = 5;
  localparam int K1 = 8, ND1 = 16, L1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // default instance
  logic                          start0, sm0, ce0, busy0, done0;
  logic [M-1:0][K-1:0][DW-1:0]   a0;
  logic [K-1:0][N-1:0][DW-1:0]   b0;
  logic [M-1:0][N-1:0][AW-1:0]   c0;
  logic [ND-1:0][17:0]           da0, db0;
  logic [ND-1:0][36:0]           dout0;

  // latency-3 instance
  logic                          start1, sm1, ce1, busy1, done1;
  logic [M-1:0][K1-1:0][DW-1:0]  a1;
  logic [K1-1:0][N-1:0][DW-1:0]  b1;
  logic [M-1:0][N-1:0][AW-1:0]   c1;
  logic [ND1-1:0][17:0]          da1, db1;
  logic [ND1-1:0][36:0]          dout1, prod1;
  logic [ND1-1:0][36:0]          st1 [L1-1];

  matmul_dsp_sched #(
    .M(M), .K(K), .N(N), .DATA_W(DW), .ACC_W(AW), .NUM_DSP(ND), .DSP_LAT(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(sm0),
    .a(a0), .b(b0), .c(c0), .dsp_a(da0), .dsp_b(db0), .dsp_out(dout0),
    .dsp_ce(ce0), .busy(busy0), .done(done0)
  );

  matmul_dsp_sched #(
    .M(M), .K(K1), .N(N), .DATA_W(DW), .ACC_W(AW), .NUM_DSP(ND1), .DSP_LAT(L1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(sm1),
    .a(a1), .b(b1), .c(c1), .dsp_a(da1), .dsp_b(db1), .dsp_out(dout1),
    .dsp_ce(ce1), .busy(busy1), .done(done1)
  );

  function automatic logic [36:0] mul37(input logic [17:0] x, input logic [17:0] y);
    logic signed [36:0] sx, sy;
    sx = {{19{x[17]}}, x};
    sy = {{19{y[17]}}, y};
    return sx * sy;
  endfunction

  // DSP model, latency 1: combinational product of the registered operands.
  always_comb begin
    for (int l = 0; l < ND; l++) dout0[l] = mul37(da0[l], db0[l]);
  end

  // DSP model, latency L1: product then L1-1 clock-enabled register stages.
  always_comb begin
    for (int l = 0; l < ND1; l++) prod1[l] = mul37(da1[l], db1[l]);
  end
  always_ff @(posedge clk) begin
    if (ce1) begin
      st1[0] <= prod1;
      for (int s = 1; s < L1 - 1; s++) st1[s] <= st1[s-1];
    end
  end
  assign dout1 = st1[L1-2];

  // Run u0 once. cyc counts clock edges from the start-sampling edge up to the
  // edge that closes the done cycle (-1 on timeout).
  task automatic run0(input logic sm, input int pulse_at, output int cyc,
                      output logic bm, output logic cm,
                      output logic [ND-1:0][17:0] sa,
                      output logic [M-1:0][N-1:0][AW-1:0] cl);
    int n;
    bm = 1'b0; cm = 1'b0; sa = '0;
    @(negedge clk);
    sm0 = sm;
    start0 = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start0 = 1'b0;
    cl = c0;
    while (!done0 && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start0 = (n == pulse_at);
      if (n == 10) begin bm = busy0; cm = ce0; end
      if (n == 56) sa = da0;
    end
    start0 = 1'b0;
    cyc = done0 ? n : -1;
  endtask

  task automatic run1(input logic sm, output int cyc);
    int n;
    @(negedge clk);
    sm1 = sm;
    start1 = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start1 = 1'b0;
    while (!done1 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    cyc = done1 ? n : -1;
  endtask

  task automatic test_reset();
    start0 = 1'b0; sm0 = 1'b0; a0 = '0; b0 = '0;
    start1 = 1'b0; sm1 = 1'b0; a1 = '0; b1 = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (c0 !== '0)  begin failures++; $display("FAIL reset_c0 got=%0h exp=0", c0); end
    checks++; if (da0 !== '0) begin failures++; $display("FAIL reset_dsp_a got=%0h exp=0", da0); end
    checks++; if (db0 !== '0) begin failures++; $display("FAIL reset_dsp_b got=%0h exp=0", db0); end
    checks++; if (ce0 !== 1'b0)   begin failures++; $display("FAIL reset_ce got=%b exp=0", ce0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done0); end
    checks++; if (c1 !== '0)  begin failures++; $display("FAIL reset_c1 got=%0h exp=0", c1); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
  endtask

  task automatic test_all255();
    int cyc; logic bm, cm;
    logic [ND-1:0][17:0] sa;
    logic [M-1:0][N-1:0][AW-1:0] cl;
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a0[i][k] = 8'hFF;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b0[k][j] = 8'hFF;
    run0(1'b0, -1, cyc, bm, cm, sa, cl);
    checks++; if (cyc !== 67) begin failures++; $display("FAIL all255_latency got=%0d exp=67", cyc); end
    checks++; if (bm !== 1'b1) begin failures++; $display("FAIL all255_busy_mid got=%b exp=1", bm); end
    checks++; if (cm !== 1'b1) begin failures++; $display("FAIL all255_ce_mid got=%b exp=1", cm); end
    checks++; if (sa[0] !== 18'd255) begin failures++; $display("FAIL all255_lane0_pass3 got=%0h exp=ff", sa[0]); end
    checks++; if (sa[4:1] !== '0) begin failures++; $display("FAIL all255_idle_lanes_pass3 got=%0h exp=0", sa[4:1]); end
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (c0[i][j] !== 24'd1040400) begin
        failures++; $display("FAIL all255_c[%0d][%0d] got=%0d exp=1040400", i, j, c0[i][j]);
      end
    end
    @(negedge clk);
    checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL all255_done_one_cycle got=%b exp=0", done0); end
    checks++; if (c0[3][3] !== 24'd1040400) begin failures++; $display("FAIL all255_c_hold got=%0d exp=1040400", c0[3][3]); end
  endtask

  task automatic test_identity();
    int cyc; logic bm, cm;
    logic [ND-1:0][17:0] sa;
    logic [M-1:0][N-1:0][AW-1:0] cl;
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a0[i][k] = (i == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b0[k][j] = 8'((k * 37 + j * 11 + 5) % 256);
    run0(1'b0, -1, cyc, bm, cm, sa, cl);
    checks++; if (cl !== '0) begin failures++; $display("FAIL ident_c_cleared_at_load got=%0h exp=0", cl); end
    checks++; if (cyc !== 67) begin failures++; $display("FAIL ident_latency got=%0d exp=67", cyc); end
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (c0[i][j] !== AW'(b0[i][j])) begin
        failures++; $display("FAIL ident_c[%0d][%0d] got=%0d exp=%0d", i, j, c0[i][j], b0[i][j]);
      end
    end
  endtask

  task automatic test_signed();
    int cyc; logic bm, cm;
    logic [ND-1:0][17:0] sa;
    logic [M-1:0][N-1:0][AW-1:0] cl;
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a0[i][k] = 8'h80;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b0[k][j] = 8'h80;
    run0(1'b1, -1, cyc, bm, cm, sa, cl);
    checks++; if (sa[0] !== 18'h3FF80) begin failures++; $display("FAIL signed_ext_lane0 got=%0h exp=3ff80", sa[0]); end
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (c0[i][j] !== 24'd262144) begin
        failures++; $display("FAIL signed_m128_c[%0d][%0d] got=%0d exp=262144", i, j, c0[i][j]);
      end
    end
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a0[i][k] = 8'hFF;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b0[k][j] = 8'h01;
    run0(1'b1, -1, cyc, bm, cm, sa, cl);
    checks++; if (sa[0] !== 18'h3FFFF) begin failures++; $display("FAIL signed_ext_m1 got=%0h exp=3ffff", sa[0]); end
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (c0[i][j] !== 24'hFFFFF0) begin
        failures++; $display("FAIL signed_m1_c[%0d][%0d] got=%0h exp=fffff0", i, j, c0[i][j]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int cyc; logic bm, cm; logic seen_busy;
    logic [ND-1:0][17:0] sa;
    logic [M-1:0][N-1:0][AW-1:0] cl;
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a0[i][k] = 8'd3;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b0[k][j] = 8'd2;
    run0(1'b0, 20, cyc, bm, cm, sa, cl);
    checks++; if (cyc !== 67) begin failures++; $display("FAIL midstart_latency got=%0d exp=67", cyc); end
    checks++; if (c0[1][2] !== 24'd96) begin failures++; $display("FAIL midstart_c got=%0d exp=96", c0[1][2]); end
    start0 = 1'b1;                      // pulse during the done cycle
    @(negedge clk);
    start0 = 1'b0;
    seen_busy = 1'b0;
    repeat (3) begin @(negedge clk); seen_busy |= busy0; end
    checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL donestart_ignored busy_seen=%b exp=0", seen_busy); end
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a0[i][k] = 8'd1;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b0[k][j] = 8'd5;
    run0(1'b0, -1, cyc, bm, cm, sa, cl);
    checks++; if (cyc !== 67) begin failures++; $display("FAIL restart_latency got=%0d exp=67", cyc); end
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
      checks++;
      if (c0[i][j] !== 24'd80) begin
        failures++; $display("FAIL restart_c[%0d][%0d] got=%0d exp=80", i, j, c0[i][j]);
      end
    end
  endtask

  task automatic test_lat3();
    int cyc, s;
    logic [AW-1:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      logic sm;
      sm = (pass == 0);
      for (int i = 0; i < M; i++) for (int k = 0; k < K1; k++) a1[i][k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < K1; k++) for (int j = 0; j < N; j++) b1[k][j] = 8'($urandom_range(0, 255));
      run1(sm, cyc);
      checks++; if (cyc !== 13) begin failures++; $display("FAIL lat3_latency sm=%b got=%0d exp=13", sm, cyc); end
      for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < K1; k++) begin
          if (sm) s += int'($signed(a1[i][k])) * int'($signed(b1[k][j]));
          else    s += int'(a1[i][k]) * int'(b1[k][j]);
        end
        exp = AW'(s);
        checks++;
        if (c1[i][j] !== exp) begin
          failures++; $display("FAIL lat3_c[%0d][%0d] sm=%b got=%0h exp=%0h", i, j, sm, c1[i][j], exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, dones; logic bm, cm;
    logic [ND-1:0][17:0] sa;
    logic [M-1:0][N-1:0][AW-1:0] cl;
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a0[i][k] = 8'hFF;
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b0[k][j] = 8'hFF;
    @(negedge clk);
    sm0 = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (39) @(negedge clk);         // inside pass 2
    rst_n = 1'b0;
    #1;
    checks++; if (c0 !== '0)      begin failures++; $display("FAIL midreset_c got=%0h exp=0", c0); end
    checks++; if (da0 !== '0)     begin failures++; $display("FAIL midreset_dsp_a got=%0h exp=0", da0); end
    checks++; if (ce0 !== 1'b0)   begin failures++; $display("FAIL midreset_ce got=%b exp=0", ce0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy0); end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (80) begin @(negedge clk); if (done0) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
    run0(1'b0, -1, cyc, bm, cm, sa, cl);
    checks++; if (cyc !== 67) begin failures++; $display("FAIL postreset_latency got=%0d exp=67", cyc); end
    checks++; if (c0[2][1] !== 24'd1040400) begin failures++; $display("FAIL postreset_c got=%0d exp=1040400", c0[2][1]); end
  endtask

  initial begin
    test_reset();
    test_all255();
    test_identity();
    test_signed();
    test_start_ignored();
    test_lat3();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
